// File: rtl/gradient_rom_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency gradient colour ROM between NUM_REQ requesters.
// Optional GRAD_ARB_STATS_EN adds per-requester saturating stall counters (stall_cnt, stats_clr).
module gradient_rom_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 24
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
`ifdef GRAD_ARB_STATS_EN
  input  logic                          stats_clr,
  output logic [NUM_REQ*16-1:0]         stall_cnt,
`endif
  input  logic [DATA_WIDTH-1:0]         rom_dout
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 16;

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      grant_idx;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    tag1;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic                  found;
  logic                  transfer;
  int unsigned           cand;

  // Round-robin search starting one past the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[PTR_W'(cand)]) begin
        grant[PTR_W'(cand)] = 1'b1;
        grant_idx           = PTR_W'(cand);
        found               = 1'b1;
      end
    end
  end

  // Address of the winning requester.
  always_comb begin
    grant_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[PTR_W'(i)]) grant_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign req_ready = en ? grant : '0;
  assign transfer  = |req_ready;
  assign rsp_data  = rom_dout;

  // Address/tag pipeline; tags line up with the ROM's registered output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr  <= '0;
      rr_ptr    <= PTR_W'(NUM_REQ - 1);
      tag1      <= '0;
      rsp_valid <= '0;
    end else begin
      rsp_valid <= tag1;
      if (transfer) begin
        rom_addr <= grant_addr;
        rr_ptr   <= grant_idx;
        tag1     <= req_ready;
      end else begin
        tag1     <= '0;
      end
    end
  end

`ifdef GRAD_ARB_STATS_EN
  // Per-requester stall counters: valid but not granted, saturating, clear has priority.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stall
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
      end else if (stats_clr) begin
        cnt <= '0;
      end else if (req_valid[gi] && !req_ready[gi] && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
    assign stall_cnt[gi*CNT_W +: CNT_W] = cnt;
  end
`endif

endmodule
